fc_ctrl: RTL and testbench

FC_CTRL -- requirements
Module: fc_ctrl

---
 rtl/fc_ctrl.sv | 146 ++++++++++++++
 tb/tb_fc_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_ctrl.sv
// Sequencer for one fully-connected layer: loads the input vector into the CIM
// input buffer, runs one bit-serial CIM pass per bit plane, then hands off to fc_func.
//   state     | meaning
//   s_idle    | waiting for i_start
//   s_load    | writing input elements into the buffer tiles
//   s_exec    | one-cycle kick of a CIM pass for bit plane bit_count
//   s_wait    | waiting for that pass to report done
//   s_handoff | holding o_func_start until fc_func reports busy
module fc_ctrl #(
  parameter int input_size    = 257,
  parameter int xbar_size     = 256,
  parameter int v_cim_tiles   = (input_size + xbar_size - 1) / xbar_size,
  parameter int datatype_size = 8,
  parameter int TW            = (v_cim_tiles > 1) ? $clog2(v_cim_tiles) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_start,
  input  logic                             i_valid,
  input  logic [datatype_size-1:0]         i_data,
  input  logic                             i_cim_done,
  input  logic                             i_func_busy,
  output logic                             o_busy,
  output logic                             o_cim_busy,
  output logic                             o_ibuf_we,
  output logic [$clog2(xbar_size)-1:0]     o_ibuf_addr,
  output logic [TW-1:0]                    o_ibuf_tile,
  output logic [datatype_size-1:0]         o_ibuf_data,
  output logic                             o_cim_exec,
  output logic [$clog2(datatype_size)-1:0] o_bit_sel,
  output logic                             o_func_start
);

  localparam int AW = $clog2(xbar_size);
  localparam int BW = $clog2(datatype_size);
  localparam int LW = (input_size > 1) ? $clog2(input_size) : 1;

  typedef enum logic [2:0] {
    s_idle    = 3'd0,
    s_load    = 3'd1,
    s_exec    = 3'd2,
    s_wait    = 3'd3,
    s_handoff = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] load_count_q, load_count_d;
  logic [BW-1:0] bit_count_q, bit_count_d;
  logic [31:0]   load_ext;

  assign load_ext = 32'(load_count_q);

  always_comb begin
    state_d      = state_q;
    load_count_d = load_count_q;
    bit_count_d  = bit_count_q;
    case (state_q)
      s_idle: begin
        load_count_d = '0;
        bit_count_d  = '0;
        if (i_start) state_d = s_load;
      end
      s_load: begin
        if (i_valid) begin
          if (load_count_q == LW'(input_size - 1)) begin
            load_count_d = '0;
            state_d      = s_exec;
          end else begin
            load_count_d = load_count_q + LW'(1);
          end
        end
      end
      s_exec: state_d = s_wait;
      s_wait: begin
        if (i_cim_done) begin
          if (bit_count_q == BW'(datatype_size - 1)) begin
            bit_count_d = '0;
            state_d     = s_handoff;
          end else begin
            bit_count_d = bit_count_q + BW'(1);
            state_d     = s_exec;
          end
        end
      end
      s_handoff: if (i_func_busy) state_d = s_idle;
      default: begin
        state_d      = s_idle;
        load_count_d = '0;
        bit_count_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= s_idle;
      load_count_q <= '0;
      bit_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      load_count_q <= load_count_d;
      bit_count_q  <= bit_count_d;
    end
  end

  // Outputs are forced low for the whole reset cycle, not just after the edge.
  always_comb begin
    o_busy       = 1'b0;
    o_cim_busy   = 1'b0;
    o_ibuf_we    = 1'b0;
    o_ibuf_addr  = '0;
    o_ibuf_tile  = '0;
    o_ibuf_data  = '0;
    o_cim_exec   = 1'b0;
    o_bit_sel    = '0;
    o_func_start = 1'b0;
    if (!rst) begin
      o_bit_sel = bit_count_q;
      case (state_q)
        s_load: begin
          o_busy      = 1'b1;
          o_cim_busy  = 1'b1;
          o_ibuf_we   = i_valid;
          o_ibuf_data = i_data;
          o_ibuf_addr = AW'(load_ext % xbar_size);
          o_ibuf_tile = TW'(load_ext / xbar_size);
        end
        s_exec: begin
          o_busy     = 1'b1;
          o_cim_busy = 1'b1;
          o_cim_exec = 1'b1;
        end
        s_wait: begin
          o_busy     = 1'b1;
          o_cim_busy = 1'b1;
        end
        s_handoff: begin
          o_busy       = 1'b1;
          o_func_start = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_ctrl.sv
// Scoreboard bench for fc_ctrl at input_size=4, xbar_size=2, datatype_size=2:
// buffer writes and exec bit planes are queued up front and popped as the DUT emits them.
module tb_fc_ctrl;
  localparam int IN  = 4;
  localparam int XB  = 2;
  localparam int DTS = 2;
  localparam int TW  = 1;
  localparam int AW  = 1;
  localparam int BW  = 1;
  localparam int DW  = 2;
  localparam int OW  = 7 + AW + TW + DW + BW - 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start, i_valid, i_cim_done, i_func_busy;
  logic [DW-1:0] i_data;
  logic          o_busy, o_cim_busy, o_ibuf_we, o_cim_exec, o_func_start;
  logic [AW-1:0] o_ibuf_addr;
  logic [TW-1:0] o_ibuf_tile;
  logic [DW-1:0] o_ibuf_data;
  logic [BW-1:0] o_bit_sel;

  fc_ctrl #(.input_size(IN), .xbar_size(XB), .datatype_size(DTS)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_valid(i_valid), .i_data(i_data),
    .i_cim_done(i_cim_done), .i_func_busy(i_func_busy), .o_busy(o_busy),
    .o_cim_busy(o_cim_busy), .o_ibuf_we(o_ibuf_we), .o_ibuf_addr(o_ibuf_addr),
    .o_ibuf_tile(o_ibuf_tile), .o_ibuf_data(o_ibuf_data), .o_cim_exec(o_cim_exec),
    .o_bit_sel(o_bit_sel), .o_func_start(o_func_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TW-1:0] tile;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           wq[$];
  logic [BW-1:0] eq[$];
  logic [DW-1:0] dat[IN];
  int            tests = 0;
  int            fails = 0;

  logic          s_busy, s_cbusy, s_exec, s_fs;
  logic [BW-1:0] s_bsel;
  logic [OW-1:0] s_all;

  // One cycle: sample at the falling edge, pop scoreboard entries, then step past the rising edge.
  task automatic tick();
    wr_t           got, exp;
    logic [BW-1:0] eb;
    @(negedge clk);
    s_busy  = o_busy;
    s_cbusy = o_cim_busy;
    s_exec  = o_cim_exec;
    s_fs    = o_func_start;
    s_bsel  = o_bit_sel;
    s_all   = {o_busy, o_cim_busy, o_ibuf_we, o_ibuf_addr, o_ibuf_tile, o_ibuf_data,
               o_cim_exec, o_bit_sel, o_func_start};
    if (o_ibuf_we === 1'b1) begin
      got = {o_ibuf_tile, o_ibuf_addr, o_ibuf_data};
      tests++;
      if (wq.size() == 0) begin
        fails++;
        $display("FAIL write_sb: unexpected write got tile=%0d addr=%0d data=%0d, required none",
                 got.tile, got.addr, got.data);
      end else begin
        exp = wq.pop_front();
        if (got !== exp) begin
          fails++;
          $display("FAIL write_sb: got tile=%0d addr=%0d data=%0d, required tile=%0d addr=%0d data=%0d",
                   got.tile, got.addr, got.data, exp.tile, exp.addr, exp.data);
        end
      end
    end
    if (o_cim_exec === 1'b1) begin
      tests++;
      if (eq.size() == 0) begin
        fails++;
        $display("FAIL exec_sb: unexpected exec bit_sel=%0d, required none", o_bit_sel);
      end else begin
        eb = eq.pop_front();
        if (o_bit_sel !== eb) begin
          fails++;
          $display("FAIL exec_sb: bit_sel got %0d, required %0d", o_bit_sel, eb);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_txn(input int seed);
    for (int j = 0; j < IN; j++) begin
      dat[j] = DW'(j + seed);
      wq.push_back({TW'(j / XB), AW'(j % XB), dat[j]});
    end
    for (int b = 0; b < DTS; b++) eq.push_back(BW'(b));
  endtask

  // mode 0: continuous i_valid, mode 1: i_valid toggles 1,0,1,0...
  task automatic run_txn(input int mode, input int k, input bit start_noise,
                         input bit done_noise, input int hold, input int seed, output int lat);
    int j, n, t;
    push_txn(seed);
    i_start = 1'b1; i_valid = 1'b1; i_data = '1;
    t = 0;
    tick(); t++;
    i_start = 1'b0;
    j = 0; n = 0;
    while (j < IN && n < 40) begin
      i_valid    = (mode == 0) ? 1'b1 : (n % 2 == 0);
      i_data     = i_valid ? dat[j] : DW'(~n);
      i_start    = start_noise && (n == 1);
      i_cim_done = done_noise && (n % 2 == 1);
      tick(); t++;
      tests++;
      if (s_cbusy !== 1'b1 || s_busy !== 1'b1) begin
        fails++;
        $display("FAIL load_busy: got busy=%b cim_busy=%b, required 1 1", s_busy, s_cbusy);
      end
      if (i_valid) j++;
      n++;
    end
    tests++;
    if (j != IN) begin
      fails++;
      $display("FAIL load_timeout: got %0d elements sent, required %0d", j, IN);
    end
    i_start = 1'b0; i_valid = 1'b1; i_data = DW'($urandom);
    for (int b = 0; b < DTS; b++) begin
      i_cim_done = done_noise;
      tick(); t++;
      tests++;
      if (s_exec !== 1'b1 || s_bsel !== BW'(b)) begin
        fails++;
        $display("FAIL exec_cycle: got exec=%b bit_sel=%0d, required 1 %0d", s_exec, s_bsel, b);
      end
      for (int w = 1; w <= k; w++) begin
        i_cim_done = (w == k);
        tick(); t++;
        tests++;
        if (s_exec !== 1'b0 || s_cbusy !== 1'b1 || s_bsel !== BW'(b)) begin
          fails++;
          $display("FAIL wait_cycle: got exec=%b cim_busy=%b bit_sel=%0d, required 0 1 %0d",
                   s_exec, s_cbusy, s_bsel, b);
        end
      end
    end
    i_cim_done = 1'b0; i_valid = 1'b0; i_func_busy = 1'b0;
    lat = -1;
    for (int m = 0; m < 6 && lat < 0; m++) begin
      tick();
      if (s_fs === 1'b1) lat = t;
      t++;
    end
    tests++;
    if (lat < 0 || s_cbusy !== 1'b0 || s_busy !== 1'b1) begin
      fails++;
      $display("FAIL handoff_entry: got fs_seen=%0d busy=%b cim_busy=%b, required handoff 1 0",
               lat, s_busy, s_cbusy);
    end
    for (int h = 1; h < hold; h++) begin
      tick();
      tests++;
      if (s_fs !== 1'b1 || s_busy !== 1'b1 || s_cbusy !== 1'b0) begin
        fails++;
        $display("FAIL handoff_hold: cycle %0d got fs=%b busy=%b cim_busy=%b, required 1 1 0",
                 h, s_fs, s_busy, s_cbusy);
      end
    end
    i_func_busy = 1'b1;
    tick();
    i_func_busy = 1'b0;
    tick();
    tests++;
    if (s_busy !== 1'b0 || s_fs !== 1'b0) begin
      fails++;
      $display("FAIL return_idle: got busy=%b fs=%b, required 0 0", s_busy, s_fs);
    end
    tests++;
    if (wq.size() != 0 || eq.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: got %0d writes %0d execs outstanding, required 0 0", wq.size(), eq.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_start = 1'b1; i_valid = 1'b1; i_data = '1; i_cim_done = 1'b1; i_func_busy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests++;
      if (s_all !== '0) begin
        fails++;
        $display("FAIL reset_outputs: got %b, required 0", s_all);
      end
    end
    rst = 1'b0; i_start = 1'b0; i_valid = 1'b0; i_cim_done = 1'b0;
    tick();
    tests++;
    if (s_all !== '0) begin
      fails++;
      $display("FAIL idle_after_reset: got %b, required 0", s_all);
    end
  endtask

  task automatic test_basic();
    int lat;
    run_txn(0, 3, 1'b0, 1'b0, 1, 1, lat);
    tests++;
    if (lat != 1 + IN + DTS * (1 + 3)) begin
      fails++;
      $display("FAIL latency_k3: got %0d, required %0d", lat, 1 + IN + DTS * 4);
    end
  endtask

  task automatic test_toggle_valid();
    int lat;
    run_txn(1, 2, 1'b0, 1'b0, 1, 2, lat);
  endtask

  task automatic test_handoff_hold();
    int lat;
    run_txn(0, 1, 1'b0, 1'b0, 20, 3, lat);
  endtask

  task automatic test_done_noise();
    int lat;
    run_txn(0, 2, 1'b0, 1'b1, 1, 4, lat);
    tests++;
    if (lat != 1 + IN + DTS * (1 + 2)) begin
      fails++;
      $display("FAIL latency_noise: got %0d, required %0d", lat, 1 + IN + DTS * 3);
    end
  endtask

  task automatic test_start_in_load();
    int lat;
    run_txn(1, 1, 1'b1, 1'b0, 1, 5, lat);
  endtask

  task automatic test_reset_mid();
    int lat;
    push_txn(6);
    i_start = 1'b1; i_valid = 1'b0;
    tick();
    i_start = 1'b0;
    for (int j = 0; j < IN; j++) begin
      i_valid = 1'b1; i_data = dat[j];
      tick();
    end
    i_valid = 1'b0;
    tick();                          // exec, bit 0
    tick();                          // wait
    i_cim_done = 1'b1; tick();       // wait, done
    i_cim_done = 1'b0; tick();       // exec, bit 1
    tick();                          // wait, bit 1
    tests++;
    if (s_bsel !== 1'b1 || s_cbusy !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_wait: got bit_sel=%0d cim_busy=%b, required 1 1", s_bsel, s_cbusy);
    end
    rst = 1'b1; i_start = 1'b1;
    tick();
    tests++;
    if (s_all !== '0) begin
      fails++;
      $display("FAIL mid_reset_outputs: got %b, required 0", s_all);
    end
    rst = 1'b0; i_start = 1'b0;
    tick();
    tests++;
    if (s_all !== '0) begin
      fails++;
      $display("FAIL post_reset_idle: got %b, required 0", s_all);
    end
    for (int c = 0; c < 6; c++) begin
      i_cim_done = c[0]; i_func_busy = ~c[0];
      tick();
      tests++;
      if (s_exec !== 1'b0 || s_fs !== 1'b0 || s_busy !== 1'b0) begin
        fails++;
        $display("FAIL abandoned: got exec=%b fs=%b busy=%b, required 0 0 0", s_exec, s_fs, s_busy);
      end
    end
    i_cim_done = 1'b0; i_func_busy = 1'b0;
    run_txn(0, 2, 1'b0, 1'b0, 1, 7, lat);
    tests++;
    if (lat != 1 + IN + DTS * (1 + 2)) begin
      fails++;
      $display("FAIL restart_latency: got %0d, required %0d", lat, 1 + IN + DTS * 3);
    end
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_data = '0; i_cim_done = 1'b0; i_func_busy = 1'b0;
    test_reset();
    test_basic();
    test_toggle_valid();
    test_handoff_hold();
    test_done_noise();
    test_start_in_load();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
